stack_engine: RTL
=================

// Module: stack_engine
// PURPOSE
//  Responder side of the CPU stack interface: services PUSH/POP/XTHL/SPHL requests
//  from the execute stages (PUSH, POP, CALL, RET, RST, XTHL, SPHL all map onto these).
//  Owns the 8080 stack pointer and sequences byte-wide accesses to the data memory port.
//  Sits between the pipeline and the byte-addressed data memory; one request in flight.
// PARAMETERS
//  SP_RESET  16'hF000  stack pointer value after reset
//  ADDR_W    16        memory address width; SP width equals ADDR_W
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       engine can accept; high only in IDLE
//  req_op     in   2       00 PUSH, 01 POP, 10 XTHL, 11 SPHL
//  req_data   in   16      PUSH value / HL for XTHL / new SP for SPHL
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_data   out  16      POP/XTHL: value read from stack; PUSH/SPHL: new SP
//  sp         out  16      current stack pointer (registered)
//  mem_addr   out  16      byte address to data memory
//  mem_wen    out  1       byte write strobe
//  mem_wdata  out  8       write byte
//  mem_rdata  in   8       read byte; valid the cycle after address presented with mem_wen=0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, sp=SP_RESET, rsp_valid=0, rsp_data=0,
//    mem_wen=0, mem_addr=0, mem_wdata=0, req_ready=1 on the first edge after release.
//    An op in progress is abandoned; a PUSH/XTHL may leave one byte written.
//  - Accept on req_valid && req_ready (cycle 0); op and req_data latched, req_data may
//    change afterwards. Requests while busy are not accepted (req_valid must be held).
//  - States: IDLE, WR_HI, WR_LO, RD_LO, RD_HI, RD_WAIT, XT_WR_LO, XT_WR_HI, DONE.
//  - PUSH: c1 WR_HI addr=sp-1 wdata=D[15:8] wen=1; c2 WR_LO addr=sp-2 wdata=D[7:0]
//    wen=1, sp<=sp-2 at end of c2; c3 DONE rsp_valid=1 rsp_data=new sp.
//  - POP: c1 RD_LO addr=sp; c2 RD_HI addr=sp+1, lo<=mem_rdata; c3 RD_WAIT
//    hi<=mem_rdata, sp<=sp+2; c4 DONE rsp_data={hi,lo}.
//  - XTHL: c1 RD_LO addr=sp; c2 RD_HI addr=sp+1, lo captured; c3 XT_WR_LO addr=sp
//    wdata=L wen=1, hi captured; c4 XT_WR_HI addr=sp+1 wdata=H wen=1;
//    c5 DONE rsp_data=old {hi,lo}; sp unchanged.
//  - SPHL: sp<=req_data at accept edge; c1 DONE rsp_data=req_data.
//  - DONE always returns to IDLE next cycle; back-to-back ops: next accept in the
//    IDLE cycle after DONE (PUSH 4, POP 5, XTHL 6, SPHL 2 cycles per op).
//  - mem_wen=0 in all states except WR_HI, WR_LO, XT_WR_LO, XT_WR_HI.
//  - Arithmetic modulo 2^16: sp-1, sp-2, sp+1, sp+2 wrap silently; no overflow flag.
//  - rsp_data holds its last value between pulses.
// STRUCTURE
//  - Shared package i8080_pkg: op encodings STK_PUSH/STK_POP/STK_XTHL/STK_SPHL,
//    stack FSM state enum.
//  - Single module, no sub-module; one registered FSM, sp register, lo/hi capture
//    registers, registered memory-port outputs.
// TESTING
//  - Reset with SP_RESET=F000, PUSH 1234 -> mem[EFFF]=12, mem[EFFE]=34, sp=EFFE,
//    rsp_valid at c3 with rsp_data=EFFE.
//  - PUSH 1234 then POP -> rsp_data=1234 at c4 of POP, sp back to F000.
//  - SPHL 0000 then PUSH ABCD -> writes FFFF=AB, FFFE=CD, sp=FFFE;
//    SPHL FFFF, POP with mem[FFFF]=11, mem[0000]=22 -> rsp_data=2211, sp=0001.
//  - Stack holds 5566 at EFFE, XTHL req_data=7788 -> rsp_data=5566,
//    mem[EFFE]=88, mem[EFFF]=77, sp unchanged.
//  - req_valid held during POP -> req_ready low c1..c4, second op accepted only in
//    the IDLE cycle after DONE; exactly one rsp_valid pulse per op.
//  - Assert rst_n low during c1 of PUSH -> immediate IDLE, sp=F000, mem_wen=0,
//    no rsp_valid; following POP works normally.

Source files
------------

// File: rtl/i8080_pkg.sv
// i8080_pkg: shared stack interface encodings and stack engine FSM states.
package i8080_pkg;
    typedef enum logic [1:0] {
        STK_PUSH = 2'b00,
        STK_POP  = 2'b01,
        STK_XTHL = 2'b10,
        STK_SPHL = 2'b11
    } stk_op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_HI, S_WR_LO, S_RD_LO, S_RD_HI,
        S_RD_WAIT, S_XT_WR_LO, S_XT_WR_HI, S_DONE
    } stk_state_e;
endpackage

// File: rtl/stack_engine.sv
// stack_engine: owns the 8080 stack pointer and sequences byte-wide stack accesses
// for PUSH/POP/XTHL/SPHL requests, one request in flight.
module stack_engine
    import i8080_pkg::*;
#(
    parameter logic [15:0] SP_RESET = 16'hF000,
    parameter int          ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [15:0]       req_data,
    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    stk_state_e  state;
    stk_op_e     op;
    logic [15:0] data;
    logic [7:0]  lo, hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op        <= STK_PUSH;
            data      <= '0;
            lo        <= '0;
            hi        <= '0;
            sp        <= ADDR_W'(SP_RESET);
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            mem_wen   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op        <= stk_op_e'(req_op);
                        data      <= req_data;
                        req_ready <= 1'b0;
                        // Memory-port outputs are registered, so c1's address is set up here
                        if (req_op == STK_PUSH) begin
                            state     <= S_WR_HI;
                            mem_addr  <= sp - ADDR_W'(1);
                            mem_wdata <= req_data[15:8];
                            mem_wen   <= 1'b1;
                        end else if (req_op == STK_SPHL) begin
                            state     <= S_DONE;
                            sp        <= ADDR_W'(req_data);
                            rsp_data  <= req_data;
                            rsp_valid <= 1'b1;
                        end else begin
                            state    <= S_RD_LO;
                            mem_addr <= sp;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WR_HI: begin
                    state     <= S_WR_LO;
                    mem_addr  <= sp - ADDR_W'(2);
                    mem_wdata <= data[7:0];
                    mem_wen   <= 1'b1;
                end
                S_WR_LO: begin
                    state     <= S_DONE;
                    sp        <= sp - ADDR_W'(2);
                    rsp_data  <= 16'(sp - ADDR_W'(2));
                    rsp_valid <= 1'b1;
                end
                S_RD_LO: begin
                    state    <= S_RD_HI;
                    mem_addr <= sp + ADDR_W'(1);
                end
                S_RD_HI: begin
                    lo <= mem_rdata;
                    if (op == STK_XTHL) begin
                        state     <= S_XT_WR_LO;
                        mem_addr  <= sp;
                        mem_wdata <= data[7:0];
                        mem_wen   <= 1'b1;
                    end else begin
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    state     <= S_DONE;
                    hi        <= mem_rdata;
                    sp        <= sp + ADDR_W'(2);
                    rsp_data  <= {mem_rdata, lo};
                    rsp_valid <= 1'b1;
                end
                S_XT_WR_LO: begin
                    state     <= S_XT_WR_HI;
                    hi        <= mem_rdata;
                    mem_addr  <= sp + ADDR_W'(1);
                    mem_wdata <= data[15:8];
                    mem_wen   <= 1'b1;
                end
                S_XT_WR_HI: begin
                    state     <= S_DONE;
                    rsp_data  <= {hi, lo};
                    rsp_valid <= 1'b1;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
